// File: rtl/fib_arbiter.sv
// Round-robin arbiter sharing one four-phase fib core among NUM_CLI clients.
// Optional core watchdog enabled by defining FIB_ARB_TIMEOUT_EN.
module fib_arbiter #(
  parameter int NUM_CLI = 4,
  parameter int N_IN    = 10,
  parameter int N_OUT   = 24,
  parameter int TIMEOUT = 4096,
  localparam int ID_W   = (NUM_CLI <= 2) ? 1 : $clog2(NUM_CLI)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CLI-1:0]      cli_req,
  input  logic [NUM_CLI*N_IN-1:0] cli_n,
  output logic [NUM_CLI-1:0]      cli_ack,
  output logic [N_OUT-1:0]        cli_result,
  output logic                    cli_err,
  output logic                    core_req,
  output logic [N_IN-1:0]         core_n,
  input  logic                    core_ack,
  input  logic [N_OUT-1:0]        core_result,
  output logic                    busy,
  output logic [ID_W-1:0]         grant_id
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CORE_REQ = 2'd1,
    CORE_REL = 2'd2,
    CLI_ACK  = 2'd3
  } state_t;

  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_CLI - 1);
  localparam logic [ID_W:0]   NUM_CLI_W = (ID_W+1)'(NUM_CLI);

  state_t               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic                 core_req_q, core_req_d;
  logic [N_IN-1:0]      core_n_q, core_n_d;
  logic [NUM_CLI-1:0]   cli_ack_q, cli_ack_d;
  logic [N_OUT-1:0]     cli_result_q, cli_result_d;

  logic [N_IN-1:0]      n_arr    [NUM_CLI];
  logic [ID_W-1:0]      cand_idx [NUM_CLI];
  logic [NUM_CLI-1:0]   cand_vld;
  logic [ID_W-1:0]      pick_idx;
  logic                 pick_any;
  logic [NUM_CLI-1:0]   grant_onehot;
  logic                 grant_req;

  // Candidate k is the client k places after rr_ptr, wrapping modulo NUM_CLI.
  for (genvar gi = 0; gi < NUM_CLI; gi++) begin : g_cli
    logic [ID_W:0] sum;
    assign n_arr[gi]    = cli_n[gi*N_IN +: N_IN];
    assign sum          = {1'b0, rr_ptr_q} + (ID_W+1)'(gi);
    assign cand_idx[gi] = (sum >= NUM_CLI_W) ? ID_W'(sum - NUM_CLI_W) : ID_W'(sum);
    assign cand_vld[gi] = cli_req[cand_idx[gi]];
  end

  always_comb begin
    pick_any = |cli_req;
    pick_idx = '0;
    for (int k = NUM_CLI - 1; k >= 0; k--) begin
      if (cand_vld[k]) pick_idx = cand_idx[k];
    end
  end

  assign grant_onehot = NUM_CLI'(1) << grant_q;
  assign grant_req    = cli_req[grant_q];

`ifdef FIB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cli_err_q, cli_err_d;
  logic             wd_fire;

  assign wd_fire = (cnt_q == CNT_LAST);
  assign cli_err = cli_err_q;
`else
  assign cli_err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    core_req_d   = core_req_q;
    core_n_d     = core_n_q;
    cli_ack_d    = cli_ack_q;
    cli_result_d = cli_result_q;
`ifdef FIB_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    cli_err_d    = cli_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        // Hold off while a previously aborted core transaction still shows ack.
        if (pick_any && !core_ack) begin
          grant_d    = pick_idx;
          core_n_d   = n_arr[pick_idx];
          rr_ptr_d   = (pick_idx == LAST_ID) ? '0 : pick_idx + 1'b1;
          core_req_d = 1'b1;
          state_d    = CORE_REQ;
`ifdef FIB_ARB_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      CORE_REQ: begin
`ifdef FIB_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (core_ack) begin
          cli_result_d = core_result;
          core_req_d   = 1'b0;
          state_d      = CORE_REL;
        end
`ifdef FIB_ARB_TIMEOUT_EN
        else if (wd_fire) begin
          core_req_d   = 1'b0;
          cli_result_d = '0;
          if (grant_req) begin
            cli_ack_d = grant_onehot;
            cli_err_d = 1'b1;
            state_d   = CLI_ACK;
          end else begin
            state_d   = IDLE;
          end
        end
`endif
      end
      CORE_REL: begin
`ifdef FIB_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (!core_ack) begin
          if (grant_req) begin
            cli_ack_d = grant_onehot;
            state_d   = CLI_ACK;
          end else begin
            state_d   = IDLE;
          end
        end
`ifdef FIB_ARB_TIMEOUT_EN
        else if (wd_fire) begin
          // Core ack stuck high: report the captured result, flagged as an error.
          if (grant_req) begin
            cli_ack_d = grant_onehot;
            cli_err_d = 1'b1;
            state_d   = CLI_ACK;
          end else begin
            state_d   = IDLE;
          end
        end
`endif
      end
      CLI_ACK: begin
        if (!grant_req) begin
          cli_ack_d = '0;
          state_d   = IDLE;
`ifdef FIB_ARB_TIMEOUT_EN
          cli_err_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      core_req_q   <= 1'b0;
      core_n_q     <= '0;
      cli_ack_q    <= '0;
      cli_result_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      core_req_q   <= core_req_d;
      core_n_q     <= core_n_d;
      cli_ack_q    <= cli_ack_d;
      cli_result_q <= cli_result_d;
    end
  end

`ifdef FIB_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      cli_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      cli_err_q <= cli_err_d;
    end
  end
`endif

  assign cli_ack    = cli_ack_q;
  assign cli_result = cli_result_q;
  assign core_req   = core_req_q;
  assign core_n     = core_n_q;
  assign busy       = (state_q != IDLE);
  assign grant_id   = grant_q;

endmodule
